// File: rtl/init_seq_pkg.sv
// Shared constants for the fabric reset sequencer: FSM state encoding and
// the width of the status-loss event counter.
package init_seq_pkg;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_STABLE = 3'd1,
    S_PERIPH = 3'd2,
    S_RUN    = 3'd3,
    S_SWRST  = 3'd4
  } seq_state_t;

  localparam int DROP_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Parameterised-width two-flop synchronizer for slow asynchronous status
// levels; both stages clear to 0 on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/init_reset_sequencer.sv
// Power-up reset sequencer: holds peripheral and core resets until all init
// monitor statuses are stable, releases peripheral first, then core.
module init_reset_sequencer
  import init_seq_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int CORE_DELAY    = 16,
  parameter int SWRST_CYCLES  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fabric_por_n,
  input  logic              device_init_done,
  input  logic              bank_vddi_ok,
  input  logic              bank_calib_ok,
  input  logic              pll_lock,
  input  logic              sw_reset_req,
  output logic              periph_reset,
  output logic              core_reset,
  output logic              sys_ready,
  output logic [2:0]        seq_state,
  output logic [DROP_W-1:0] drop_count
);

  localparam int MAX_P = (STABLE_CYCLES > CORE_DELAY)
                         ? ((STABLE_CYCLES > SWRST_CYCLES) ? STABLE_CYCLES : SWRST_CYCLES)
                         : ((CORE_DELAY > SWRST_CYCLES) ? CORE_DELAY : SWRST_CYCLES);
  localparam int CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_DELAY - 1);
  localparam logic [CNT_W-1:0] SWRST_LAST  = CNT_W'(SWRST_CYCLES - 1);

  logic [4:0]        status_sync;
  logic              all_ok;
  logic              sw_prev_reg;
  logic              sw_rise;
  seq_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DROP_W-1:0] drop_reg, drop_next;
  logic              periph_reset_reg, core_reset_reg, sys_ready_reg;

  sync_2ff #(.WIDTH(5)) u_status_sync (
    .clk (clk),
    .rst (rst),
    .d   ({fabric_por_n, device_init_done, bank_vddi_ok, bank_calib_ok, pll_lock}),
    .q   (status_sync)
  );

  assign all_ok  = &status_sync;
  assign sw_rise = sw_reset_req & ~sw_prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= S_WAIT;
      cnt_reg          <= '0;
      drop_reg         <= '0;
      sw_prev_reg      <= 1'b0;
      periph_reset_reg <= 1'b1;
      core_reset_reg   <= 1'b1;
      sys_ready_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      drop_reg         <= drop_next;
      sw_prev_reg      <= sw_reset_req;
      // Outputs decoded from the next state so they switch with seq_state.
      periph_reset_reg <= (state_next == S_WAIT) || (state_next == S_STABLE);
      core_reset_reg   <= (state_next != S_RUN);
      sys_ready_reg    <= (state_next == S_RUN);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    drop_next  = drop_reg;
    case (state_reg)
      S_WAIT: begin
        if (all_ok) state_next = S_STABLE;
      end
      S_STABLE: begin
        // A glitch before release is not a drop event; just restart the window.
        if (!all_ok) state_next = S_WAIT;
        else if (cnt_reg == STABLE_LAST) state_next = S_PERIPH;
      end
      S_PERIPH: begin
        if (!all_ok) state_next = S_WAIT;
        else if (cnt_reg == CORE_LAST) state_next = S_RUN;
      end
      S_RUN: begin
        if (!all_ok) state_next = S_WAIT;
        else if (sw_rise) state_next = S_SWRST;
      end
      S_SWRST: begin
        if (!all_ok) state_next = S_WAIT;
        else if (cnt_reg == SWRST_LAST) state_next = S_RUN;
      end
      default: state_next = S_WAIT;
    endcase
    if (!all_ok && (state_reg == S_PERIPH || state_reg == S_RUN || state_reg == S_SWRST)
        && drop_reg != {DROP_W{1'b1}}) begin
      drop_next = drop_reg + DROP_W'(1);
    end
    if (state_next != state_reg) cnt_next = '0;
  end

  assign periph_reset = periph_reset_reg;
  assign core_reset   = core_reset_reg;
  assign sys_ready    = sys_ready_reg;
  assign seq_state    = state_reg;
  assign drop_count   = drop_reg;

endmodule

// File: tb/tb_init_reset_sequencer.sv
// Directed bench for init_reset_sequencer with STABLE=4, CORE_DELAY=3, SWRST=2.
module tb_init_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       fabric_por_n, device_init_done, bank_vddi_ok, bank_calib_ok, pll_lock;
  logic       sw_reset_req;
  logic       periph_reset, core_reset, sys_ready;
  logic [2:0] seq_state;
  logic [7:0] drop_count;

  int errors = 0;
  int checks = 0;
  int exp_drop = 0;

  init_reset_sequencer #(
    .STABLE_CYCLES (4),
    .CORE_DELAY    (3),
    .SWRST_CYCLES  (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fabric_por_n     (fabric_por_n),
    .device_init_done (device_init_done),
    .bank_vddi_ok     (bank_vddi_ok),
    .bank_calib_ok    (bank_calib_ok),
    .pll_lock         (pll_lock),
    .sw_reset_req     (sw_reset_req),
    .periph_reset     (periph_reset),
    .core_reset       (core_reset),
    .sys_ready        (sys_ready),
    .seq_state        (seq_state),
    .drop_count       (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_all(input logic v);
    fabric_por_n = v; device_init_done = v; bank_vddi_ok = v;
    bank_calib_ok = v; pll_lock = v;
  endtask

  // Bounded wait for RUN; an expired bound is reported as a failed comparison.
  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (seq_state != 3'd3 && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) check_eq(tag, seq_state, 3);
  endtask

  initial begin
    int hi_cnt;
    int n;
    rst = 1'b1;
    set_all(1'b0);
    sw_reset_req = 1'b0;
    tick(3);
    check_eq("rst_periph", periph_reset, 1);
    check_eq("rst_core", core_reset, 1);
    check_eq("rst_ready", sys_ready, 0);
    check_eq("rst_state", seq_state, 0);
    rst = 1'b0;
    tick(3);

    // Power-up: inputs rise after edge E
    set_all(1'b1);
    tick(2);
    check_eq("pu_wait_e2", seq_state, 0);
    tick(1);
    check_eq("pu_stable_e3", seq_state, 1);
    tick(3);
    check_eq("pu_periph_hold_e6", periph_reset, 1);
    tick(1);
    check_eq("pu_periph_rel_e7", periph_reset, 0);
    check_eq("pu_core_hold_e7", core_reset, 1);
    check_eq("pu_state_e7", seq_state, 2);
    tick(2);
    check_eq("pu_core_hold_e9", core_reset, 1);
    tick(1);
    check_eq("pu_core_rel_e10", core_reset, 0);
    check_eq("pu_ready_e10", sys_ready, 1);
    check_eq("pu_drop", drop_count, 0);

    // Software reset: request held high for 10 cycles
    sw_reset_req = 1'b1;
    tick(1);
    check_eq("sw_core_d1", core_reset, 1);
    check_eq("sw_state_d1", seq_state, 4);
    check_eq("sw_periph_d1", periph_reset, 0);
    check_eq("sw_ready_d1", sys_ready, 0);
    tick(1);
    check_eq("sw_core_d2", core_reset, 1);
    tick(1);
    check_eq("sw_core_d3", core_reset, 0);
    check_eq("sw_state_d3", seq_state, 3);
    hi_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      if (core_reset) hi_cnt++;
    end
    check_eq("sw_no_retrigger", hi_cnt, 0);
    sw_reset_req = 1'b0;
    tick(1);

    // Loss in RUN
    bank_calib_ok = 1'b0;
    tick(2);
    check_eq("loss_run_e2", seq_state, 3);
    tick(1);
    exp_drop++;
    check_eq("loss_state_e3", seq_state, 0);
    check_eq("loss_periph_e3", periph_reset, 1);
    check_eq("loss_core_e3", core_reset, 1);
    check_eq("loss_drop", drop_count, exp_drop);
    bank_calib_ok = 1'b1;
    tick(10);
    check_eq("loss_rerun_ready", sys_ready, 1);

    // Simultaneous sw edge and status loss: loss wins
    pll_lock = 1'b0;
    tick(2);
    sw_reset_req = 1'b1;
    tick(1);
    exp_drop++;
    check_eq("simul_state", seq_state, 0);
    check_eq("simul_drop", drop_count, exp_drop);
    sw_reset_req = 1'b0;
    tick(3);

    // Glitch on the second STABLE cycle
    pll_lock = 1'b1;
    tick(3);
    check_eq("gl_stable_s", seq_state, 1);
    tick(1);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    check_eq("gl_stable_s3", seq_state, 1);
    tick(1);
    check_eq("gl_wait_s4", seq_state, 0);
    check_eq("gl_drop", drop_count, exp_drop);
    tick(1);
    check_eq("gl_restart_s5", seq_state, 1);
    tick(3);
    check_eq("gl_periph_hold_s8", periph_reset, 1);
    tick(1);
    check_eq("gl_periph_rel_s9", periph_reset, 0);
    wait_run("gl_run_timeout");

    // Saturation of drop_count via repeated losses after peripheral release
    for (int i = 0; i < 300; i++) begin
      set_all(1'b1);
      n = 0;
      while (periph_reset && n < 40) begin
        tick(1);
        n++;
      end
      if (n >= 40) begin
        check_eq("sat_timeout", periph_reset, 0);
        break;
      end
      device_init_done = 1'b0;
      tick(3);
      if (exp_drop < 255) exp_drop++;
      if (i == 99) check_eq("sat_mid", drop_count, exp_drop);
    end
    check_eq("sat_final", drop_count, 255);

    // Async reset mid-PERIPH, between clock edges
    set_all(1'b1);
    tick(7);
    check_eq("ar_in_periph", seq_state, 2);
    #3;
    rst = 1'b1;
    #1;
    check_eq("ar_periph", periph_reset, 1);
    check_eq("ar_core", core_reset, 1);
    check_eq("ar_ready", sys_ready, 0);
    check_eq("ar_state", seq_state, 0);
    check_eq("ar_drop", drop_count, 0);
    #2;
    rst = 1'b0;
    wait_run("ar_rerun_timeout");
    check_eq("ar_rerun_ready", sys_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/init_reset_sequencer.md
# init_reset_sequencer

Sequences fabric resets after device power-up, driven by the status outputs of the PolarFire init monitor (fabric POR, device init done, bank VDDI status, bank calibration status) plus the system PLL lock. Holds the peripheral and RISC-V core resets asserted until every status has been stable for a programmable time, then releases the peripheral reset first and the core reset later. It re-enters reset if any status drops, and provides a software-requested core-only reset. It sits between the init monitor wrapper and the reset inputs of the SoC top level.

## Interface
- STABLE_CYCLES, 1024: consecutive cycles with all status good before peripheral release; must be ≥1.
- CORE_DELAY, 16: cycles between peripheral release and core release; must be ≥1.
- SWRST_CYCLES, 8: core reset pulse length for a software request; must be ≥1.
- clk  in  1  system clock, sole clock domain.
- rst  in  1  asynchronous, active-high reset.
- fabric_por_n  in  1  async; 1 = fabric POR released.
- device_init_done  in  1  async; device init complete.
- bank_vddi_ok  in  1  async; I/O bank VDDI present.
- bank_calib_ok  in  1  async; HSIO bank calibration done.
- pll_lock  in  1  async; system PLL locked.
- sw_reset_req  in  1  sync to clk; rising edge requests a core reset.
- periph_reset  out  1  active-high peripheral reset.
- core_reset  out  1  active-high core reset.
- sys_ready  out  1  1 only in RUN.
- seq_state  out  3  current state encoding, for debug.
- drop_count  out  8  saturating count of status-loss events.

## Operation
- Each of the five async status inputs passes through a 2-flop synchronizer. all_ok = AND of the synchronized values.
- States and encodings: WAIT=0, STABLE=1, PERIPH=2, RUN=3, SWRST=4. Encodings 5–7 are illegal and go to WAIT.
- WAIT: both resets asserted. all_ok → STABLE with cnt=0.
- STABLE: cnt increments each cycle. On !all_ok → WAIT, with no drop count. On cnt==STABLE_CYCLES-1 with all_ok → PERIPH, cnt=0.
- PERIPH: periph_reset=0, core_reset=1. On cnt==CORE_DELAY-1 → RUN.
- RUN: both resets 0, sys_ready=1. A sw_reset_req rising edge (registered previous value, 0→1) → SWRST with cnt=0.
- SWRST: periph_reset=0, core_reset=1, sys_ready=0. On cnt==SWRST_CYCLES-1 → RUN.
- Status loss: !all_ok in PERIPH, RUN or SWRST → WAIT next edge and drop_count += 1, saturating at 255.
- Priority: !all_ok beats counter expiry, which beats a sw request. sw requests outside RUN are ignored and not queued. A request level held high across a SWRST does not retrigger; a new 0→1 edge is needed.
- cnt width is $clog2 of the largest parameter plus 1. cnt resets to 0 on every state change.

## Timing
- rst asserted gives, asynchronously: state=WAIT, periph_reset=1, core_reset=1, sys_ready=0, seq_state=0, drop_count=0, cnt=0, synchronizers=0, sw edge register=0.
- Outputs come from flops loaded with the next-state decode, so they change on the same edge as seq_state and are glitch-free.
- Input-to-all_ok latency is 2 cycles. A status rising at edge E starts STABLE at E+3. periph_reset falls at E+3+STABLE_CYCLES. core_reset falls CORE_DELAY cycles after that.
- Status loss: an input falling at edge E gives WAIT and both resets asserted at E+3.
- A sw edge sampled at edge E gives core_reset=1 at E+1 for exactly SWRST_CYCLES cycles.
- rst asserted mid-sequence aborts immediately. The sequence restarts from WAIT after rst is removed.

## Structure
- Package init_seq_pkg holds the state encoding constants (WAIT..SWRST) and the drop_count width constant.
- Sub-module sync_2ff is a parameterised-width 2-flop synchronizer with async active-high reset to 0. It is instantiated once, with width 5.
- The FSM, counter, edge detect and output flops live in the top module.

## Test plan
Use STABLE_CYCLES=4, CORE_DELAY=3, SWRST_CYCLES=2 unless stated.
- Power-up: all inputs go to 1 at edge 10 → periph_reset falls at edge 17, core_reset and sys_ready change at edge 20, drop_count=0.
- Glitch during STABLE: pll_lock low for 1 cycle on the 2nd STABLE cycle → return to WAIT with drop_count still 0, and the full 4-cycle STABLE window restarts.
- Loss in RUN: bank_calib_ok drops → both resets are 1 three edges later, drop_count=1, and the sequence re-runs once the input recovers.
- Software reset: sw_reset_req 0→1 and held for 10 cycles in RUN → core_reset=1 for exactly 2 cycles, periph_reset stays 0, and only one pulse is produced.
- Simultaneous events: a sw edge in the same cycle that all_ok falls → WAIT, not SWRST. Forcing 300 status drops → drop_count saturates at 255.
- Async reset: assert rst mid-PERIPH, between edges → all outputs return to reset values with no clock edge needed.
